range_tracker: RTL and testbench
================================

# range_tracker

Parametrised streaming min/max/range tracker with a qualified data stream, sample counting and an explicit session state machine. It sits between a sampled data source and a result consumer. A `go`/`finish` pair brackets a measurement session. At the end of a session the block latches min, max, range and sample count as a stable result set, and reports protocol misuse through an error code.

## Interface
Parameters:
- `WIDTH`, 16: sample width, unsigned.
- `CNT_WIDTH`, 12: sample counter width.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `data_in` in WIDTH: unsigned sample.
- `data_valid` in 1: `data_in` is a sample this cycle.
- `go` in 1: start a session (level-sampled each cycle).
- `finish` in 1: end the session.
- `busy` out 1: session in progress (state RUN).
- `live_min` out WIDTH: running minimum. 0 until the first sample of a session.
- `live_max` out WIDTH: running maximum. 0 until the first sample of a session.
- `res_min`, `res_max`, `res_range` out WIDTH: latched results of the last good session.
- `res_count` out CNT_WIDTH: samples in the last good session, saturating.
- `res_ovf` out 1: the sample count saturated during the last good session.
- `done` out 1: result set valid.
- `err` out 2: error code, held until the next accepted `go`. Values: 0 none, 1 both (`go`&`finish`), 2 no session, 3 empty session.

## Operation
- States: IDLE, RUN, DONE, ERROR. Reset state is IDLE.
- Reset values: all outputs 0, count 0, `first` flag set.
- Evaluation per cycle, in priority order:
  1. `go`&`finish` in any state → ERROR, `err`=1, `done`=0, `busy`=0. Live registers clear.
  2. `go` in IDLE/DONE/ERROR → RUN. `err`=0, `done`=0. Live registers and count clear, `first` set. A `data_valid` sample in this same cycle is accepted as the first sample.
  3. `go` in RUN → restart. Same as item 2; the current session is discarded, no error.
  4. `finish` in RUN with total samples (including one on this cycle) ≥1 → DONE. Latch results, `done`=1.
  5. `finish` in RUN with zero samples → ERROR, `err`=3.
  6. `finish` in IDLE/DONE/ERROR → ERROR, `err`=2, `done`=0. Previous `res_*` values are retained but not valid.
  7. Otherwise hold state. In RUN, accept a sample whenever `data_valid`=1.
- Sample accept:
  - If `first`: min=max=`data_in`, clear `first`.
  - Else: min updates when `data_in` < min (strict); max updates when `data_in` > max (strict).
  - Count increments and saturates at 2^CNT_WIDTH−1. Reaching saturation and receiving another sample sets a sticky `ovf`.
- Result latch on a DONE transition:
  - Uses the values after the finish-cycle sample is folded in.
  - `res_range` = `res_max` − `res_min`, unsigned, always ≥0, no wrap possible.
- `data_valid` outside RUN is ignored, except on an accepted `go` cycle.

## Timing
- All state and outputs are registered. No combinational input→output paths.
- Sample on cycle N → `live_min`/`live_max` reflect it at N+1.
- `finish` on cycle N → `done`, `res_*`, `busy`=0 at N+1.
- `go` on cycle N → `busy`=1, `done`=0, `err`=0 at N+1.
- `done` stays high through DONE until the next `go` or an error.
- Reset mid-session: immediate return to IDLE with all outputs 0. No result is produced.
- Back-to-back sessions: `finish` on N and `go` on N+1 is legal. `done` is high for exactly the one cycle N+1 → N+2.

## Structure
- Package `range_tracker_pkg`:
  - `state_t` enum (IDLE, RUN, DONE, ERROR).
  - `err_t` enum: ERR_NONE, ERR_BOTH, ERR_NOSESSION, ERR_EMPTY.
- Sub-module `extreme_tracker`:
  - Parameters: WIDTH and a compare direction (MIN/MAX).
  - Inputs: `load`, `sample`, `clear`.
  - Instantiated twice.
- Sample counter and FSM live in the top level.

## Test plan
- Basic session: `go`, then samples 40, 7, 99, 12, then `finish` (no sample on the `finish` cycle) → `res_min`=7, `res_max`=99, `res_range`=92, `res_count`=4, `done`=1 one cycle after `finish`.
- Finish-cycle sample:
  - `go` with `data_valid` and 5 on the same cycle, then `finish` with `data_valid` and 300 on the same cycle.
  - → `res_min`=5, `res_max`=300, `res_count`=2.
- Error cases:
  - `go`&`finish` together → `err`=1.
  - `finish` while IDLE → `err`=2.
  - `go` then `finish` with no `data_valid` → `err`=3, `done`=0.
  - Next `go` clears `err` to 0.
- Saturation: CNT_WIDTH=3, feed 9 samples → `res_count`=7, `res_ovf`=1; min/max remain correct.
- Restart and reset:
  - `go`, sample 1, `go` again, sample 50, `finish` → min=max=50, `res_range`=0, count 1.
  - Separately: reset asserted mid-RUN → all outputs 0 asynchronously, state IDLE.
- Sweep all-ones: WIDTH=16, samples 0 and 65535 → `res_range`=65535.

Source files
------------

// File: rtl/range_tracker_pkg.sv
// Shared types for the min/max/range tracker: session states, error codes,
// and the compare direction used by the extreme tracker.
package range_tracker_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE, ERROR} state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_BOTH, ERR_NOSESSION, ERR_EMPTY} err_t;
  typedef enum logic {DIR_MIN, DIR_MAX} dir_t;
endpackage

// File: rtl/extreme_tracker.sv
// Running minimum or maximum of an accepted sample stream. next_value exposes
// the post-update value so the parent can latch a result in the same cycle.
module extreme_tracker
  import range_tracker_pkg::*;
#(
  parameter int   WIDTH = 16,
  parameter dir_t DIR   = DIR_MIN
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] next_value
);
  logic first, first_nxt, better;

  assign better = (DIR == DIR_MIN) ? (sample < value) : (sample > value);

  // A clear and a load in the same cycle make the sample the first of the new run.
  always_comb begin
    next_value = value;
    first_nxt  = first;
    if (clear) begin
      next_value = '0;
      first_nxt  = 1'b1;
    end
    if (load) begin
      if (first_nxt || better) next_value = sample;
      first_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= '0;
      first <= 1'b1;
    end else begin
      value <= next_value;
      first <= first_nxt;
    end
  end
endmodule

// File: rtl/range_tracker.sv
// Session-bracketed min/max/range tracker with saturating sample count.
// go/finish delimit a session; results latch on a good finish.
module range_tracker
  import range_tracker_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 data_valid,
  input  logic                 go,
  input  logic                 finish,
  output logic                 busy,
  output logic [WIDTH-1:0]     live_min,
  output logic [WIDTH-1:0]     live_max,
  output logic [WIDTH-1:0]     res_min,
  output logic [WIDTH-1:0]     res_max,
  output logic [WIDTH-1:0]     res_range,
  output logic [CNT_WIDTH-1:0] res_count,
  output logic                 res_ovf,
  output logic                 done,
  output logic [1:0]           err
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t               state;
  logic                 both, accept, ovf, ovf_nxt;
  logic [CNT_WIDTH-1:0] count, count_nxt;
  logic [WIDTH-1:0]     min_nxt, max_nxt;

  assign both   = go & finish;
  // Samples count in RUN and on the go cycle itself; a go&finish cycle takes none.
  assign accept = data_valid & ~both & (go | (state == RUN));

  extreme_tracker #(.WIDTH(WIDTH), .DIR(DIR_MIN)) u_min (
    .clock(clock), .reset(reset), .clear(go), .load(accept),
    .sample(data_in), .value(live_min), .next_value(min_nxt)
  );

  extreme_tracker #(.WIDTH(WIDTH), .DIR(DIR_MAX)) u_max (
    .clock(clock), .reset(reset), .clear(go), .load(accept),
    .sample(data_in), .value(live_max), .next_value(max_nxt)
  );

  always_comb begin
    count_nxt = count;
    ovf_nxt   = ovf;
    if (go) begin
      count_nxt = {{(CNT_WIDTH-1){1'b0}}, accept};
      ovf_nxt   = 1'b0;
    end else if (accept) begin
      if (count == CNT_MAX) ovf_nxt = 1'b1;
      else                  count_nxt = count + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= ERR_NONE;
      count     <= '0;
      ovf       <= 1'b0;
      res_min   <= '0;
      res_max   <= '0;
      res_range <= '0;
      res_count <= '0;
      res_ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      ovf   <= ovf_nxt;
      if (both) begin
        state <= ERROR;
        err   <= ERR_BOTH;
        done  <= 1'b0;
        busy  <= 1'b0;
      end else if (go) begin
        state <= RUN;
        err   <= ERR_NONE;
        done  <= 1'b0;
        busy  <= 1'b1;
      end else if (finish && state == RUN) begin
        busy <= 1'b0;
        // count_nxt is zero only when no sample was seen all session.
        if (count_nxt != '0) begin
          state     <= DONE;
          done      <= 1'b1;
          res_min   <= min_nxt;
          res_max   <= max_nxt;
          res_range <= max_nxt - min_nxt;
          res_count <= count_nxt;
          res_ovf   <= ovf_nxt;
        end else begin
          state <= ERROR;
          err   <= ERR_EMPTY;
        end
      end else if (finish) begin
        state <= ERROR;
        err   <= ERR_NOSESSION;
        done  <= 1'b0;
        busy  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_range_tracker.sv
// Directed bench for range_tracker: a session-level model (sample queue plus
// result set) is compared against the DUT every cycle, plus literal checks.
module tb_range_tracker;
  localparam int W  = 16;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0, reset = 1'b1;
  logic [W-1:0]  data_in = '0;
  logic          data_valid = 1'b0, go = 1'b0, finish = 1'b0;
  logic          busy, res_ovf, done;
  logic [W-1:0]  live_min, live_max, res_min, res_max, res_range;
  logic [CW-1:0] res_count;
  logic [1:0]    err;

  range_tracker #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .go(go), .finish(finish), .busy(busy), .live_min(live_min), .live_max(live_max),
    .res_min(res_min), .res_max(res_max), .res_range(res_range),
    .res_count(res_count), .res_ovf(res_ovf), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0;

  // Model: 0 idle, 1 run, 2 done, 3 error
  int           m_state;
  logic [W-1:0] q[$];
  int           m_err, m_done, m_rmin, m_rmax, m_rrange, m_rcount, m_rovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int qmin();
    int m;
    if (q.size() == 0) return 0;
    m = q[0];
    foreach (q[i]) if (q[i] < m) m = q[i];
    return m;
  endfunction

  function automatic int qmax();
    int m = 0;
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  task automatic model_reset();
    m_state = 0; q.delete();
    m_err = 0; m_done = 0; m_rmin = 0; m_rmax = 0; m_rrange = 0; m_rcount = 0; m_rovf = 0;
  endtask

  task automatic model_step(input logic g, input logic f, input logic v, input logic [W-1:0] d);
    if (g && f) begin
      m_state = 3; m_err = 1; m_done = 0; q.delete();
    end else if (g) begin
      m_state = 1; m_err = 0; m_done = 0; q.delete();
      if (v) q.push_back(d);
    end else if (f && m_state == 1) begin
      if (v) q.push_back(d);
      if (q.size() == 0) begin
        m_state = 3; m_err = 3;
      end else begin
        m_state = 2; m_done = 1;
        m_rmin = qmin(); m_rmax = qmax(); m_rrange = m_rmax - m_rmin;
        m_rcount = (q.size() > CMAX) ? CMAX : q.size();
        m_rovf = (q.size() > CMAX) ? 1 : 0;
      end
    end else if (f) begin
      m_state = 3; m_err = 2; m_done = 0;
    end else if (m_state == 1 && v) begin
      q.push_back(d);
    end
  endtask

  task automatic compare();
    chk("busy", busy, (m_state == 1) ? 1 : 0);
    chk("done", done, m_done);
    chk("err", err, m_err);
    chk("live_min", live_min, qmin());
    chk("live_max", live_max, qmax());
    chk("res_min", res_min, m_rmin);
    chk("res_max", res_max, m_rmax);
    chk("res_range", res_range, m_rrange);
    chk("res_count", res_count, m_rcount);
    chk("res_ovf", res_ovf, m_rovf);
  endtask

  task automatic step(input logic g, input logic f, input logic v, input logic [W-1:0] d);
    go = g; finish = f; data_valid = v; data_in = d;
    @(posedge clock);
    model_step(g, f, v, d);
    @(negedge clock);
    go = 1'b0; finish = 1'b0; data_valid = 1'b0;
    compare();
  endtask

  task automatic sample(input logic [W-1:0] d);
    step(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_busy", busy, 0);
    chk("rst_live_min", live_min, 0);
    chk("rst_live_max", live_max, 0);
    chk("rst_done", done, 0);
    chk("rst_res_max", res_max, 0);
    chk("rst_err", err, 0);
    @(negedge clock);
    reset = 1'b0;
    compare();
  endtask

  initial begin
    model_reset();
    #2;
    chk("por_busy", busy, 0);
    chk("por_done", done, 0);
    chk("por_res_count", res_count, 0);
    @(negedge clock);
    reset = 1'b0;
    compare();

    // samples outside a session are ignored
    sample(16'd3);
    chk("idle_ignore", live_min, 0);

    // basic session
    step(1, 0, 0, 0);
    chk("go_busy", busy, 1);
    sample(16'd40); sample(16'd7); sample(16'd99); sample(16'd12);
    step(0, 1, 0, 0);
    chk("basic_done", done, 1);
    chk("basic_min", res_min, 7);
    chk("basic_max", res_max, 99);
    chk("basic_range", res_range, 92);
    chk("basic_count", res_count, 4);
    step(0, 0, 0, 0);
    chk("done_hold", done, 1);

    // sample on go and finish cycles, then back-to-back go
    step(1, 0, 1, 16'd5);
    step(0, 1, 1, 16'd300);
    chk("fc_min", res_min, 5);
    chk("fc_max", res_max, 300);
    chk("fc_count", res_count, 2);
    step(1, 0, 0, 0);
    chk("b2b_done_low", done, 0);

    // errors
    step(1, 1, 1, 16'd9);
    chk("err_both", err, 1);
    do_reset();
    step(0, 1, 0, 0);
    chk("err_nosession", err, 2);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("err_empty", err, 3);
    chk("err_empty_done", done, 0);
    step(1, 0, 0, 0);
    chk("err_cleared", err, 0);

    // saturation: 9 samples into a 3-bit counter
    sample(16'd20); sample(16'd15); sample(16'd300); sample(16'd4); sample(16'd4);
    sample(16'd1000); sample(16'd8); sample(16'd999); sample(16'd2);
    step(0, 1, 0, 0);
    chk("sat_count", res_count, 7);
    chk("sat_ovf", res_ovf, 1);
    chk("sat_min", res_min, 2);
    chk("sat_max", res_max, 1000);

    // restart discards the previous partial session
    step(1, 0, 0, 0); sample(16'd1);
    step(1, 0, 0, 0); sample(16'd50);
    step(0, 1, 0, 0);
    chk("rs_min", res_min, 50);
    chk("rs_range", res_range, 0);
    chk("rs_count", res_count, 1);
    chk("rs_ovf", res_ovf, 0);

    // reset mid-session
    step(1, 0, 0, 0); sample(16'd77);
    do_reset();

    // full-scale range
    step(1, 0, 1, 16'd0);
    sample(16'hFFFF);
    step(0, 1, 0, 0);
    chk("sweep_range", res_range, 65535);
    step(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
